// File: rtl/dds_phase_seq_pkg.sv
// Shared DDS constants.
// Holds the CORDIC angle encoding, the CORDIC gain constant and the
// sequencer state encoding used by dds_phase_seq and dds_quad_fold.
// Angle units: binary angle, full scale +/-2^19 == +/-pi for a 20-bit angle,
// so pi/2 is 2^18.
package dds_phase_seq_pkg;

    // Fractional bits taken from the phase below the quadrant bits.
    localparam int FOLD_W = 18;

    // CORDIC angle-unit encoding of pi/2 (pi == 2^19).
    localparam logic [19:0] HALF_PI_ANG = 20'h4_0000;

    // CORDIC gain compensation, K = 0.6072529 scaled by 2^19.
    localparam logic [19:0] CORDIC_GAIN = 20'd318375;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/dds_quad_fold.sv
// Phase-to-angle fold.
// Maps the top bits of the phase accumulator onto a first-quadrant CORDIC
// angle plus a sign flag. Purely combinational.
// Ports:
//   phase_top : top FOLD_W+2 bits of the phase (2 quadrant bits + fraction)
//   angle     : folded angle in CORDIC units, range 0..pi/2
//   neg       : result must be negated (quadrants 2 and 3)
module dds_quad_fold
    import dds_phase_seq_pkg::*;
#(
    parameter int ANG_W = 20
) (
    input  logic [FOLD_W+1:0] phase_top,
    output logic [ANG_W-1:0]  angle,
    output logic              neg
);

    localparam int PROD_W = FOLD_W + 1 + ANG_W;
    localparam logic [FOLD_W:0] QUARTER = {1'b1, {FOLD_W{1'b0}}};

    logic [1:0]        quad;
    logic [FOLD_W-1:0] frac;
    logic [FOLD_W:0]   mag;
    logic [PROD_W-1:0] prod;

    always_comb begin
        quad = phase_top[FOLD_W+1 -: 2];
        frac = phase_top[FOLD_W-1:0];
        // Odd quadrants run the angle backwards from pi/2; f = 0 there
        // needs the full 2^18, hence the extra magnitude bit.
        mag  = quad[0] ? (QUARTER - {1'b0, frac}) : {1'b0, frac};
        prod = PROD_W'(mag) * PROD_W'(HALF_PI_ANG);
        // Truncating scale back by 2^FOLD_W.
        angle = ANG_W'(prod >> FOLD_W);
        neg   = quad[1];
    end

endmodule

// File: rtl/dds_phase_seq.sv
// DDS phase sequencer.
// Advances a phase accumulator on each enabled sample tick, folds the phase
// into a first-quadrant angle, hands it to an external CORDIC, and returns
// the sign-corrected sine as a sample. Sticky flags report ticks that arrive
// while a conversion is in flight (overrun) and CORDIC responses that never
// come back (timeout).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : sample generation enable
//   ftw            : frequency tuning word, sampled on each enabled tick
//   sample_tick    : one-cycle sample-rate strobe
//   err_clr        : clears overrun/timeout
//   cordic_angle   : angle to CORDIC, held through ISSUE and WAIT
//   cordic_update  : CORDIC start strobe (high during ISSUE)
//   cordic_y       : CORDIC sine result
//   cordic_ready   : CORDIC result-valid strobe (only honoured in WAIT)
//   sample_out     : signed sine sample, held between samples
//   sample_valid   : sample strobe (high during OUT)
//   overrun        : sticky, tick while busy
//   timeout        : sticky, CORDIC watchdog expired
module dds_phase_seq
    import dds_phase_seq_pkg::*;
#(
    parameter int PHASE_W  = 32,
    parameter int ANG_W    = 20,
    parameter int WD_LIMIT = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               sample_tick,
    input  logic               err_clr,
    output logic [ANG_W-1:0]   cordic_angle,
    output logic               cordic_update,
    input  logic [ANG_W-1:0]   cordic_y,
    input  logic               cordic_ready,
    output logic [ANG_W-1:0]   sample_out,
    output logic               sample_valid,
    output logic               overrun,
    output logic               timeout
);

    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [ANG_W-1:0] S_MIN = {1'b1, {(ANG_W-1){1'b0}}};
    localparam logic [ANG_W-1:0] S_MAX = {1'b0, {(ANG_W-1){1'b1}}};

    seq_state_e         state, state_nx;
    logic [PHASE_W-1:0] phase;
    logic [WD_W-1:0]    wd;
    logic               neg;

    logic [ANG_W-1:0]   fold_angle;
    logic               fold_neg;
    logic [ANG_W-1:0]   signed_y;

    logic               adv;
    logic               start;
    logic               got_ready;
    logic               wd_expire;

    dds_quad_fold #(
        .ANG_W (ANG_W)
    ) u_fold (
        .phase_top (phase[PHASE_W-1 -: FOLD_W+2]),
        .angle     (fold_angle),
        .neg       (fold_neg)
    );

    // Every enabled tick moves the phase, busy or not.
    assign adv = sample_tick & enable;

    // Next-state and strobe outputs.
    always_comb begin
        state_nx      = state;
        start         = 1'b0;
        got_ready     = 1'b0;
        wd_expire     = 1'b0;
        cordic_update = 1'b0;
        sample_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (adv) begin
                    state_nx = ISSUE;
                    start    = 1'b1;
                end
            end
            ISSUE: begin
                cordic_update = 1'b1;
                state_nx      = WAIT;
            end
            WAIT: begin
                // A response on the last watchdog cycle still counts.
                if (cordic_ready) begin
                    state_nx  = OUT;
                    got_ready = 1'b1;
                end else if (wd == WD_W'(WD_LIMIT - 1)) begin
                    state_nx  = IDLE;
                    wd_expire = 1'b1;
                end
            end
            OUT: begin
                sample_valid = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sign correction; the most negative code has no positive twin, so it
    // clamps to full-scale positive.
    always_comb begin
        if (!neg)
            signed_y = cordic_y;
        else if (cordic_y == S_MIN)
            signed_y = S_MAX;
        else
            signed_y = -cordic_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= '0;
            wd           <= '0;
            neg          <= 1'b0;
            cordic_angle <= '0;
            sample_out   <= '0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state <= state_nx;

            if (adv)
                phase <= phase + ftw;

            // Angle comes from the pre-increment phase.
            if (start) begin
                cordic_angle <= fold_angle;
                neg          <= fold_neg;
            end

            // Watchdog counts WAIT cycles only; cleared on the way in.
            if (state == ISSUE)
                wd <= '0;
            else if (state == WAIT)
                wd <= wd + 1'b1;

            if (got_ready)
                sample_out <= signed_y;

            // Set beats clear when both land in the same cycle.
            if (adv && (state != IDLE))
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;

            if (wd_expire)
                timeout <= 1'b1;
            else if (err_clr)
                timeout <= 1'b0;
        end
    end

endmodule

// File: doc/dds_phase_seq.md
DDS_PHASE_SEQ -- requirements
Module: dds_phase_seq

Interface
REQ-001 Parameters (name, default, meaning): PHASE_W, 32, phase accumulator width; ANG_W, 20, CORDIC angle/sample width; WD_LIMIT, 24, CORDIC response watchdog in cycles.
REQ-002 Clocking: reset reset, synchronous, active-high; clock clk.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, sample generation enable.
- ftw, in, PHASE_W, frequency tuning word.
- sample_tick, in, 1, one-cycle sample-rate strobe.
- err_clr, in, 1, clears sticky error flags.
- cordic_angle, out, ANG_W, signed angle to the CORDIC.
- cordic_update, out, 1, one-cycle CORDIC start strobe.
- cordic_y, in, ANG_W, signed CORDIC sine result.
- cordic_ready, in, 1, CORDIC result-valid strobe.
- sample_out, out, ANG_W, signed sine sample.
- sample_valid, out, 1, one-cycle sample strobe.
- overrun, out, 1, sticky: sample_tick arrived while busy.
- timeout, out, 1, sticky: watchdog expired.

Function
REQ-004 The block SHALL hold phase accumulator P (PHASE_W bits), wrapping modulo 2^PHASE_W.
REQ-005 On every sample_tick with enable=1, P SHALL advance P <= P + ftw, regardless of FSM state; ftw SHALL be sampled on that tick.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
- IDLE -> ISSUE on sample_tick & enable.
- ISSUE -> WAIT after 1 cycle.
- WAIT -> OUT on cordic_ready.
- WAIT -> IDLE when the watchdog reaches WD_LIMIT.
- OUT -> IDLE after 1 cycle.
REQ-007 In IDLE, the tick that starts a conversion SHALL latch the pre-increment P value. q = P[MSB:MSB-1]. f = next 18 bits below q.
REQ-008 Angle mapping SHALL use an unsigned 18x20 product with the result truncated:
- Quadrants 0 and 2: angle = (f * HALF_PI_ANG) >> 18.
- Quadrants 1 and 3: angle = ((2^18 - f) * HALF_PI_ANG) >> 18.
- neg = q[1].
REQ-009 cordic_angle SHALL be registered in the IDLE->ISSUE transition and held stable through ISSUE and WAIT.
REQ-010 cordic_update SHALL be 1 exactly during ISSUE.
REQ-011 On cordic_ready in WAIT, sample_out SHALL register neg ? -cordic_y : cordic_y, with saturation: negating -2^(ANG_W-1) gives 2^(ANG_W-1)-1.
- sample_valid SHALL be 1 exactly during OUT.
- sample_out SHALL hold its value until the next OUT.
REQ-012 Latency SHALL be fixed relative to ready: with the tick at cycle 0, update is at cycle 1 and sample_valid is 1 cycle after cordic_ready.
REQ-013 A sample_tick with enable=1 in ISSUE, WAIT or OUT SHALL:
- set overrun;
- advance P;
- not start a conversion.
REQ-014 cordic_ready outside WAIT SHALL be ignored.
REQ-015 The watchdog SHALL count WAIT cycles; reaching WD_LIMIT SHALL set timeout and return to IDLE with no sample_valid.
REQ-016 err_clr SHALL clear overrun and timeout; a set event in the same cycle SHALL win.
REQ-017 With enable=0:
- ticks SHALL be ignored, with P frozen and no overrun;
- an in-flight conversion SHALL complete normally.

Reset
REQ-018 Reset SHALL take priority over all inputs and be honoured in any state, including mid-conversion.
REQ-019 Reset values: P=0, state=IDLE, cordic_angle=0, cordic_update=0, sample_out=0, sample_valid=0, overrun=0, timeout=0, watchdog=0.

Structure
REQ-020 HALF_PI_ANG (the CORDIC angle-unit encoding of pi/2) and the FSM state encoding SHALL live in the shared DDS constants package alongside the CORDIC gain constant.
REQ-021 The phase-to-angle fold (REQ-007/008) SHALL be a combinational sub-module dds_quad_fold; the FSM, accumulator, watchdog and output logic SHALL stay in dds_phase_seq.

Verification
REQ-022 ftw=0x40000000, 4 ticks spaced 40 cycles, real CORDIC attached -> samples ~0, ~+max, ~0, ~-max, each within CORDIC error tolerance.
REQ-023 Tick at cycle 0 -> cordic_update high only at cycle 1; sample_valid exactly 1 cycle after cordic_ready.
REQ-024 Second tick 5 cycles after the first -> overrun=1, single sample_valid, P advanced by 2*ftw; err_clr -> overrun=0.
REQ-025 CORDIC model never asserts ready -> timeout=1 after WD_LIMIT WAIT cycles, no sample_valid, FSM back in IDLE; the next tick converts normally.
REQ-026 Quadrant 3 with model cordic_y=-2^19 -> sample_out=2^19-1 (saturation).
REQ-027 Reset asserted during WAIT -> all outputs at reset values next cycle; a late cordic_ready produces no sample_valid.
